// File: rtl/xg_pcs_pkg.sv
// Shared constants and block type for the 10GBASE-R PCS datapath.
package xg_pcs_pkg;
    localparam logic [1:0] SYNC_DATA       = 2'b01;
    localparam logic [1:0] SYNC_CTRL       = 2'b10;
    localparam logic [7:0] BLOCK_TYPE_IDLE = 8'h1E;
    localparam int         GEARBOX_SEQ_PAUSE = 32;
    localparam int         SCR_WORD_W      = 32;
    localparam int         SCR_STATE_W     = 58;

    typedef struct packed {
        logic [1:0]  header;
        logic [63:0] data;
    } xg_block_t;

    localparam xg_block_t IDLE_BLOCK = '{header: SYNC_CTRL, data: {56'h0, BLOCK_TYPE_IDLE}};
endpackage

// File: rtl/xg_scrambler32.sv
// Self-synchronous 1 + x^39 + x^58 scrambler, 32 bits per enabled cycle, LSB first.
module xg_scrambler32
    import xg_pcs_pkg::*;
#(
    parameter logic [SCR_STATE_W-1:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                   tx_clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   bypass,
    input  logic [SCR_WORD_W-1:0]  din,
    output logic [SCR_WORD_W-1:0]  dout,
    output logic [SCR_STATE_W-1:0] state
);
    logic [SCR_STATE_W-1:0] s;
    logic [SCR_STATE_W-1:0] state_nxt;
    logic [SCR_WORD_W-1:0]  scr;

    always_comb begin
        s   = state;
        scr = '0;
        for (int i = 0; i < SCR_WORD_W; i++) begin
            scr[i] = din[i] ^ s[38] ^ s[57];
            s      = {s[SCR_STATE_W-2:0], scr[i]};
        end
        state_nxt = s;
        dout      = bypass ? din : scr;
    end

    // Bypass freezes the state so scrambling resumes where it left off.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else if (en && !bypass)
            state <= state_nxt;
    end
endmodule

// File: rtl/xg_pcs_tx_gearbox_feeder.sv
// Feeds 66-bit PCS blocks to the GTY TX synchronous gearbox as 32-bit words,
// scrambling payloads and substituting idle blocks when upstream is empty.
module xg_pcs_tx_gearbox_feeder
    import xg_pcs_pkg::*;
#(
    parameter logic [57:0] SCRAMBLER_SEED = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int          SEQ_PAUSE      = GEARBOX_SEQ_PAUSE
) (
    input  logic        tx_clk,
    input  logic        rst_n,
    input  logic        scrambler_bypass,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [1:0]  blk_header,
    input  logic [63:0] blk_data,
    output logic [31:0] tx_data,
    output logic [1:0]  tx_header,
    output logic        tx_header_valid,
    output logic [6:0]  tx_sequence,
    output logic        idle_inserted
);
    logic [6:0]  seq;
    logic        hold_full;
    xg_block_t   hold;
    xg_block_t   launch_blk;
    logic [31:0] hi_word;
    logic [31:0] word;
    logic [31:0] scr_word;
    logic [57:0] scr_state;
    logic        pause;
    logic        first_half;
    logic        accept;
    logic        hold_full_nxt;

    always_comb begin
        pause         = (seq == 7'(SEQ_PAUSE));
        first_half    = !pause && !seq[0];
        accept        = blk_valid && blk_ready;
        launch_blk    = hold_full ? hold : IDLE_BLOCK;
        word          = first_half ? launch_blk.data[31:0] : hi_word;
        // A same-cycle accept refills the entry being launched.
        hold_full_nxt = accept || (hold_full && !first_half);
    end

    xg_scrambler32 #(.SEED(SCRAMBLER_SEED)) u_scr (
        .tx_clk (tx_clk),
        .rst_n  (rst_n),
        .en     (!pause),
        .bypass (scrambler_bypass),
        .din    (word),
        .dout   (scr_word),
        .state  (scr_state)
    );

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            seq             <= '0;
            hold_full       <= 1'b0;
            hold            <= '0;
            hi_word         <= '0;
            blk_ready       <= 1'b0;
            tx_data         <= '0;
            tx_header       <= '0;
            tx_header_valid <= 1'b0;
            tx_sequence     <= '0;
            idle_inserted   <= 1'b0;
        end else begin
            seq             <= pause ? 7'd0 : seq + 7'd1;
            tx_sequence     <= seq;
            hold_full       <= hold_full_nxt;
            blk_ready       <= !hold_full_nxt;
            if (accept)
                hold <= '{header: blk_header, data: blk_data};
            if (first_half) begin
                hi_word   <= launch_blk.data[63:32];
                tx_header <= launch_blk.header;
            end
            tx_header_valid <= first_half;
            idle_inserted   <= first_half && !hold_full;
            if (!pause)
                tx_data <= scr_word;
        end
    end
endmodule

// File: tb/tb_xg_pcs_tx_gearbox_feeder.sv
// Directed and randomised checks of the TX gearbox feeder against a block-level reference.
module tb_xg_pcs_tx_gearbox_feeder;
    import xg_pcs_pkg::*;

    logic        tx_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scrambler_bypass = 1'b1;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [1:0]  blk_header = 2'b00;
    logic [63:0] blk_data = '0;
    logic [31:0] tx_data;
    logic [1:0]  tx_header;
    logic        tx_header_valid;
    logic [6:0]  tx_sequence;
    logic        idle_inserted;

    xg_pcs_tx_gearbox_feeder dut (
        .tx_clk          (tx_clk),
        .rst_n           (rst_n),
        .scrambler_bypass(scrambler_bypass),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_header      (blk_header),
        .blk_data        (blk_data),
        .tx_data         (tx_data),
        .tx_header       (tx_header),
        .tx_header_valid (tx_header_valid),
        .tx_sequence     (tx_sequence),
        .idle_inserted   (idle_inserted)
    );

    always #5 tx_clk = ~tx_clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference state
    int          b_seq;
    logic [57:0] m_state;
    logic [31:0] b_hi;
    logic [31:0] exp_data;
    logic [1:0]  exp_hdr;
    logic        exp_hv;
    logic        exp_idle;
    logic [6:0]  exp_seq;
    xg_block_t   q[$];
    int          n_acc = 0;

    task automatic model_reset();
        b_seq = 0; m_state = 58'h3FF_FFFF_FFFF_FFFF; b_hi = '0;
        exp_data = '0; exp_hdr = '0; exp_hv = 1'b0; exp_idle = 1'b0; exp_seq = '0;
        q.delete();
    endtask

    // Advance one clock and compute what the outputs should now show.
    task automatic tick();
        logic        acc;
        logic        byp;
        xg_block_t   blk;
        xg_block_t   nb;
        logic [31:0] w;
        logic [31:0] r;
        logic        o;
        acc = blk_valid && blk_ready;
        byp = scrambler_bypass;
        nb.header = blk_header;
        nb.data   = blk_data;
        @(posedge tx_clk); #1;
        exp_seq = 7'(b_seq);
        if (b_seq != 32 && (b_seq % 2) == 0) begin
            if (q.size() > 0) begin
                blk = q.pop_front(); exp_idle = 1'b0;
            end else begin
                blk.header = 2'b10; blk.data = 64'h0000_0000_0000_001E; exp_idle = 1'b1;
            end
            exp_hdr = blk.header; exp_hv = 1'b1;
            w = blk.data[31:0]; b_hi = blk.data[63:32];
        end else begin
            exp_hv = 1'b0; exp_idle = 1'b0; w = b_hi;
        end
        if (b_seq != 32) begin
            if (byp) exp_data = w;
            else begin
                r = '0;
                for (int i = 0; i < 32; i++) begin
                    o = w[i] ^ m_state[38] ^ m_state[57];
                    r[i] = o;
                    m_state = {m_state[56:0], o};
                end
                exp_data = r;
            end
        end
        b_seq = (b_seq == 32) ? 0 : b_seq + 1;
        if (acc) begin q.push_back(nb); n_acc++; end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_total++;
        if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, blk_ready} !== '0)
            $display("FAIL reset_outputs got data=%h hdr=%b hv=%b seq=%0d idle=%b rdy=%b required all 0",
                     tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, blk_ready);
        else n_pass++;
        model_reset();
        @(posedge tx_clk); #1 rst_n = 1'b1;
        tick();
        n_total++;
        if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {32'h0000001E, 2'b10, 1'b1, 7'd0, 1'b1})
            $display("FAIL first_idle got data=%h hdr=%b hv=%b seq=%0d idle=%b required 0000001e/10/1/0/1",
                     tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted);
        else n_pass++;
        n_total++;
        if (blk_ready !== 1'b1) $display("FAIL ready_after_reset got %b required 1", blk_ready);
        else n_pass++;
    endtask

    task automatic test_idle_bypass();
        int idles = 0;
        for (int c = 0; c < 66; c++) begin
            tick();
            if (idle_inserted === 1'b1) idles++;
            if (c == 0) begin
                n_total++;
                if (tx_data !== 32'h0 || tx_header_valid !== 1'b0)
                    $display("FAIL idle_second_half got data=%h hv=%b required 0/0", tx_data, tx_header_valid);
                else n_pass++;
            end
            n_total++;
            if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {exp_data, exp_hdr, exp_hv, exp_seq, exp_idle}) begin
                if (n_total - n_pass < 30)
                    $display("FAIL idle_stream seq=%0d got %h/%b/%b/%0d/%b required %h/%b/%b/%0d/%b", exp_seq,
                             tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, exp_data, exp_hdr, exp_hv, exp_seq, exp_idle);
            end else n_pass++;
        end
        n_total++;
        if (idles != 32) $display("FAIL idle_count got %0d required 32 in 66 cycles", idles);
        else n_pass++;
    endtask

    task automatic test_single_block();
        int  a0;
        bit  seen = 0;
        scrambler_bypass = 1'b1;
        blk_valid = 1'b1; blk_header = 2'b01; blk_data = 64'h8877665544332211;
        a0 = n_acc;
        for (int c = 0; c < 6 && n_acc == a0; c++) tick();
        blk_valid = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (tx_header_valid === 1'b1 && tx_header === 2'b01) seen = 1;
            else tick();
        end
        n_total++;
        if (!seen || tx_data !== 32'h44332211)
            $display("FAIL single_low got seen=%0d data=%h required 44332211 with hdr 01", seen, tx_data);
        else n_pass++;
        tick();
        n_total++;
        if (tx_data !== 32'h88776655 || tx_header_valid !== 1'b0)
            $display("FAIL single_high got data=%h hv=%b required 88776655/0", tx_data, tx_header_valid);
        else n_pass++;
    endtask

    task automatic test_seq31();
        int c = 0;
        blk_valid = 1'b0;
        while (!(b_seq == 31 && blk_ready === 1'b1) && c < 80) begin tick(); c++; end
        n_total++;
        if (c >= 80) $display("FAIL seq31_timeout got no ready slot at seq 31 required one within 80 cycles");
        else n_pass++;
        blk_valid = 1'b1; blk_header = 2'b01; blk_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        blk_valid = 1'b0;
        tick();
        n_total++;
        if (tx_sequence !== 7'd32 || tx_header_valid !== 1'b0)
            $display("FAIL seq31_pause got seq=%0d hv=%b required 32/0", tx_sequence, tx_header_valid);
        else n_pass++;
        tick();
        n_total++;
        if ({tx_sequence, tx_header_valid, tx_header, tx_data} !== {7'd0, 1'b1, 2'b01, 32'hCAFEF00D})
            $display("FAIL seq31_launch got seq=%0d hv=%b hdr=%b data=%h required 0/1/01/cafef00d",
                     tx_sequence, tx_header_valid, tx_header, tx_data);
        else n_pass++;
    endtask

    task automatic test_throughput();
        int          a0;
        int          cnt = 1;
        int          last;
        logic [31:0] prev;
        scrambler_bypass = 1'b1;
        blk_valid = 1'b1; blk_header = 2'b01; blk_data = {32'd1, 32'd1};
        for (int c = 0; c < 66; c++) begin
            if (c == 33) a0 = n_acc;
            prev = tx_data;
            last = n_acc;
            tick();
            if (n_acc != last) begin cnt++; blk_data = {32'(cnt), 32'(cnt) ^ 32'hA5A5_0000}; end
            n_total++;
            if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {exp_data, exp_hdr, exp_hv, exp_seq, exp_idle}) begin
                if (n_total - n_pass < 30)
                    $display("FAIL thru_stream seq=%0d got %h/%b/%b/%0d/%b required %h/%b/%b/%0d/%b", exp_seq,
                             tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, exp_data, exp_hdr, exp_hv, exp_seq, exp_idle);
            end else n_pass++;
            if (tx_sequence === 7'd32) begin
                n_total++;
                if (tx_data !== prev || tx_header_valid !== 1'b0)
                    $display("FAIL thru_pause got data=%h hv=%b required %h/0", tx_data, tx_header_valid, prev);
                else n_pass++;
            end
        end
        n_total++;
        if (n_acc - a0 != 16) $display("FAIL thru_count got %0d required 16 per 33 cycles", n_acc - a0);
        else n_pass++;
        blk_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_scrambled_random();
        int a0 = n_acc;
        int last;
        int c = 0;
        scrambler_bypass = 1'b0;
        blk_header = 2'($urandom); blk_data = {$urandom, $urandom};
        while (n_acc - a0 < 1000 && c < 5000) begin
            blk_valid = ($urandom_range(0, 9) < 8);
            last = n_acc;
            tick();
            c++;
            if (n_acc != last) begin blk_header = 2'($urandom); blk_data = {$urandom, $urandom}; end
            n_total++;
            if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {exp_data, exp_hdr, exp_hv, exp_seq, exp_idle}) begin
                if (n_total - n_pass < 30)
                    $display("FAIL scr_stream seq=%0d got %h/%b/%b/%0d/%b required %h/%b/%b/%0d/%b", exp_seq,
                             tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, exp_data, exp_hdr, exp_hv, exp_seq, exp_idle);
            end else n_pass++;
        end
        n_total++;
        if (n_acc - a0 < 1000) $display("FAIL scr_timeout got %0d blocks required 1000", n_acc - a0);
        else n_pass++;
        // Bypass toggled per word mid-stream.
        for (int k = 0; k < 120; k++) begin
            scrambler_bypass = 1'($urandom);
            blk_valid = 1'($urandom);
            last = n_acc;
            tick();
            if (n_acc != last) begin blk_header = 2'($urandom); blk_data = {$urandom, $urandom}; end
            n_total++;
            if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {exp_data, exp_hdr, exp_hv, exp_seq, exp_idle}) begin
                if (n_total - n_pass < 30)
                    $display("FAIL byp_stream seq=%0d got %h required %h", exp_seq, tx_data, exp_data);
            end else n_pass++;
        end
        blk_valid = 1'b0;
        scrambler_bypass = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        int c = 0;
        scrambler_bypass = 1'b0;
        blk_valid = 1'b1; blk_header = 2'b01; blk_data = 64'h0123_4567_89AB_CDEF;
        tick();
        while (!(exp_hv && !exp_idle) && c < 80) begin tick(); c++; end
        blk_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, blk_ready} !== '0 || c >= 80)
            $display("FAIL midreset_outputs got data=%h hdr=%b hv=%b seq=%0d idle=%b rdy=%b required all 0",
                     tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, blk_ready);
        else n_pass++;
        model_reset();
        @(posedge tx_clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted} !== {exp_data, exp_hdr, exp_hv, exp_seq, exp_idle})
                $display("FAIL midreset_restart k=%0d got %h/%b/%b/%0d/%b required %h/%b/%b/%0d/%b", k,
                         tx_data, tx_header, tx_header_valid, tx_sequence, idle_inserted, exp_data, exp_hdr, exp_hv, exp_seq, exp_idle);
            else n_pass++;
            if (k == 0) begin
                n_total++;
                if ({tx_sequence, tx_header_valid, idle_inserted, tx_header} !== {7'd0, 1'b1, 1'b1, 2'b10})
                    $display("FAIL midreset_first got seq=%0d hv=%b idle=%b hdr=%b required 0/1/1/10",
                             tx_sequence, tx_header_valid, idle_inserted, tx_header);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_bypass();
        test_single_block();
        test_seq31();
        test_throughput();
        test_scrambled_random();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
